// File: rtl/comparator_pkg.sv
// comparator_pkg: shared states, slice result encoding and helpers for comparator_slice_sequencer.
package comparator_pkg;
  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
  typedef enum logic [1:0] {CMP_LT, CMP_EQ, CMP_GT} cmp_t;
  function automatic int slice_count(input int width);
    return width / 2;
  endfunction
  // Result flags ordered {less, equal, greater}
  function automatic logic [2:0] flag_of(input cmp_t r);
    return r == CMP_LT ? 3'b100 : r == CMP_GT ? 3'b001 : 3'b010;
  endfunction
endpackage

// File: rtl/slice_compare_2_bit.sv
// slice_compare_2_bit: unsigned 2-bit magnitude compare producing a cmp_t result.
module slice_compare_2_bit
  import comparator_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  output cmp_t       res
);
  assign res = a < b ? CMP_LT : a > b ? CMP_GT : CMP_EQ;
endmodule

// File: rtl/comparator_slice_sequencer.sv
// comparator_slice_sequencer: multi-cycle MSB-first 2-bit-slice magnitude comparator.
// Define COMPARATOR_EARLY_EXIT_EN to stop at the first differing slice; otherwise latency is fixed.
module comparator_slice_sequencer
  import comparator_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clock_In,
  input  logic                  Reset_In,
  input  logic                  Start_In,
  input  logic [DATA_WIDTH-1:0] Data_A_In,
  input  logic [DATA_WIDTH-1:0] Data_B_In,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic                  A_Less_Than_B_Out,
  output logic                  A_Equal_To_B_Out,
  output logic                  A_Greater_Than_B_Out
);
  localparam int NUM_SLICES = slice_count(DATA_WIDTH);
  localparam int IW = NUM_SLICES > 1 ? $clog2(NUM_SLICES) : 1;
  if (DATA_WIDTH < 2 || DATA_WIDTH % 2 != 0) begin : g_bad_width
    $error("comparator_slice_sequencer: DATA_WIDTH must be even and >= 2");
  end
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_WIDTH-1:0] a_q, a_n, b_q, b_n;
  logic [2:0] flg, flg_n;
  logic [1:0] sl_a, sl_b;
  cmp_t res;
`ifndef COMPARATOR_EARLY_EXIT_EN
  logic dec, dec_n;
  cmp_t dres, dres_n;
`endif
  assign sl_a = 2'(a_q >> {idx, 1'b0});
  assign sl_b = 2'(b_q >> {idx, 1'b0});
  slice_compare_2_bit u_slice (.a(sl_a), .b(sl_b), .res(res));
  assign Busy_Out = state != IDLE;
  assign Done_Out = state == DONE;
  assign {A_Less_Than_B_Out, A_Equal_To_B_Out, A_Greater_Than_B_Out} = flg;
  always_comb begin
    state_n = state;
    idx_n = idx;
    a_n = a_q;
    b_n = b_q;
    flg_n = flg;
`ifndef COMPARATOR_EARLY_EXIT_EN
    dec_n = dec;
    dres_n = dres;
`endif
    case (state)
      IDLE: if (Start_In) begin
        a_n = Data_A_In;
        b_n = Data_B_In;
        idx_n = IW'(NUM_SLICES - 1);
        flg_n = 3'b000;
`ifndef COMPARATOR_EARLY_EXIT_EN
        dec_n = 1'b0;
        dres_n = CMP_EQ;
`endif
        state_n = COMPARE;
      end
      COMPARE: begin
`ifdef COMPARATOR_EARLY_EXIT_EN
        if (res != CMP_EQ || idx == '0) begin
          flg_n = flag_of(res);
          state_n = DONE;
        end else idx_n = idx - IW'(1);
`else
        // The most significant differing slice wins; later slices cannot overwrite it
        if (!dec && res != CMP_EQ) begin
          dec_n = 1'b1;
          dres_n = res;
        end
        if (idx == '0) begin
          flg_n = flag_of(dec ? dres : res);
          state_n = DONE;
        end else idx_n = idx - IW'(1);
`endif
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state <= IDLE;
      idx <= '0;
      a_q <= '0;
      b_q <= '0;
      flg <= 3'b000;
`ifndef COMPARATOR_EARLY_EXIT_EN
      dec <= 1'b0;
      dres <= CMP_EQ;
`endif
    end else begin
      state <= state_n;
      idx <= idx_n;
      a_q <= a_n;
      b_q <= b_n;
      flg <= flg_n;
`ifndef COMPARATOR_EARLY_EXIT_EN
      dec <= dec_n;
      dres <= dres_n;
`endif
    end
  end
endmodule

// File: tb/tb_comparator_slice_sequencer.sv
// tb_comparator_slice_sequencer: directed self-checking bench for comparator_slice_sequencer (DATA_WIDTH=8).
module tb_comparator_slice_sequencer;
`ifdef COMPARATOR_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  logic clk = 1'b0, rst, start;
  logic [7:0] da, db;
  logic busy, done, lt, eq, gt;
  logic [2:0] flg;
  int checks = 0, errors = 0;
  int lat, last, pulses;
  assign flg = {lt, eq, gt};
  always #5 clk = ~clk;
  comparator_slice_sequencer #(.DATA_WIDTH(8)) dut (
    .Clock_In(clk), .Reset_In(rst), .Start_In(start),
    .Data_A_In(da), .Data_B_In(db),
    .Busy_Out(busy), .Done_Out(done),
    .A_Less_Than_B_Out(lt), .A_Equal_To_B_Out(eq), .A_Greater_Than_B_Out(gt)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Accept one operation, then count cycles until Done (bounded)
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int l);
    da = a;
    db = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("flags_clear_after_accept", flg, 3'b000);
    l = 0;
    while (!done && l < 20) begin
      tick();
      l++;
    end
  endtask
  task automatic post_done(input string tag);
    tick();
    chk({tag, "_done_dropped"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; da = '0; db = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_flags", flg, 3'b000);
    run_op(8'hA5, 8'hA5, lat);
    chk("eq_latency", lat, 4);
    chk("eq_flags", flg, 3'b010);
    chk("eq_busy_in_done", busy, 1);
    post_done("eq");
    chk("eq_flags_held", flg, 3'b010);
    run_op(8'h80, 8'h7F, lat);
    chk("gt_latency", lat, EE ? 1 : 4);
    chk("gt_flags", flg, 3'b001);
    post_done("gt");
    run_op(8'h34, 8'h36, lat);
    chk("lt_slice0_latency", lat, 4);
    chk("lt_slice0_flags", flg, 3'b100);
    post_done("lt0");
    // Second start while busy must be ignored and new operands must not leak in
    da = 8'h10; db = 8'h20; start = 1'b1;
    tick();
    da = 8'hFF; db = 8'h00;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    start = 1'b0;
    chk("ignore_latency", lat, EE ? 2 : 4);
    chk("ignore_flags", flg, 3'b100);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("ignore_single_done", pulses, 0);
    chk("ignore_flags_held", flg, 3'b100);
    // Reset while the operation is still comparing
    da = 8'h00; db = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    if (!EE) tick();
    chk("pre_reset_no_done", done, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_flags", flg, 3'b000);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    run_op(8'h01, 8'h00, lat);
    chk("after_abort_latency", lat, 4);
    chk("after_abort_flags", flg, 3'b001);
    post_done("after_abort");
    // Start held high: back-to-back equal compares
    da = 8'h55; db = 8'h55; start = 1'b1;
    last = -1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) begin
        pulses++;
        chk("stream_eq", flg, 3'b010);
        if (last >= 0) chk("stream_interval", i - last, 6);
        last = i;
      end
    end
    start = 1'b0;
    chk("stream_pulses", pulses, 3);
    lat = 0;
    while (busy && lat < 10) begin
      tick();
      lat++;
    end
    chk("stream_drained", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
